pipe_stage_buf: RTL

Parametrised pipeline stage register that generalises the fixed ID/EX latch to any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control bundle and a data bundle with a per-beat valid bit.
- Uses a valid/ready handshake instead of a raw bubble level.
- Inserts NOP bubbles whose control fields are all-zero.
- Optional 2-entry skid mode so upstream ready is registered.

---
 rtl/pipe_pkg.sv | 43 ++++
 rtl/pipe_slot.sv | 51 +++++
 rtl/pipe_stage_buf.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared stage-boundary layout: control/data bundle field widths and bit offsets
// (LSB-first packing) plus the derived ID/EX bundle widths.
package pipe_pkg;

    localparam int BRANCH_W   = 6;
    localparam int J_W        = 4;
    localparam int ALUCTR_W   = 5;
    localparam int FLAG_CNT   = 13;

    localparam int BRANCH_LSB = 0;
    localparam int J_LSB      = BRANCH_LSB + BRANCH_W;
    localparam int ALUCTR_LSB = J_LSB + J_W;
    // Single-bit flags, in order: regDst aluSrc link lw lb lbu sb useshamt mem2Reg regWr memWr extOp rtype
    localparam int FLAGS_LSB  = ALUCTR_LSB + ALUCTR_W;

    localparam int BUS_W      = 32;
    localparam int SHAMT_W    = 5;
    localparam int IMM16_W    = 16;
    localparam int JADDR_W    = 26;
    localparam int REG_W      = 5;
    localparam int PC_W       = 32;

    localparam int BUSA_LSB   = 0;
    localparam int BUSB_LSB   = BUSA_LSB + BUS_W;
    localparam int SHAMT_LSB  = BUSB_LSB + BUS_W;
    localparam int IMM16_LSB  = SHAMT_LSB + SHAMT_W;
    localparam int JADDR_LSB  = IMM16_LSB + IMM16_W;
    localparam int RS_LSB     = JADDR_LSB + JADDR_W;
    localparam int RT_LSB     = RS_LSB + REG_W;
    localparam int RD_LSB     = RT_LSB + REG_W;
    localparam int PC_LSB     = RD_LSB + REG_W;

    localparam int IDEX_CTRL_W = FLAGS_LSB + FLAG_CNT;
    localparam int IDEX_DATA_W = PC_LSB + PC_W;

    typedef enum logic [1:0] {
        STAGE_IFID  = 2'd0,
        STAGE_IDEX  = 2'd1,
        STAGE_EXMEM = 2'd2,
        STAGE_MEMWB = 2'd3
    } stage_e;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry (valid + ctrl + data). Priority: reset, clear, load, drop, hold.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W     = IDEX_CTRL_W,
    parameter int DATA_W     = IDEX_DATA_W,
    parameter int CLEAR_DATA = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic              drop,
    input  logic              in_valid,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    logic              valid_r;
    logic [CTRL_W-1:0] ctrl_r;
    logic [DATA_W-1:0] data_r;

    // Entry storage; drop only retires the beat and keeps the payload.
    always_ff @(negedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            ctrl_r  <= {CTRL_W{1'b0}};
            data_r  <= {DATA_W{1'b0}};
        end else if (clear) begin
            valid_r <= 1'b0;
            ctrl_r  <= {CTRL_W{1'b0}};
            if (CLEAR_DATA != 0) begin
                data_r <= {DATA_W{1'b0}};
            end
        end else if (load) begin
            valid_r <= in_valid;
            ctrl_r  <= in_ctrl;
            data_r  <= in_data;
        end else if (drop) begin
            valid_r <= 1'b0;
        end
    end

    assign valid = valid_r;
    assign ctrl  = ctrl_r;
    assign data  = data_r;

endmodule

// File: rtl/pipe_stage_buf.sv
// Generic valid/ready pipeline stage register with optional skid entry.
// Optional performance counters are built only when PIPE_PERF_CNT_EN is defined.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int CTRL_W     = IDEX_CTRL_W,
    parameter int DATA_W     = IDEX_DATA_W,
    parameter int SKID       = 1,
    parameter int CLEAR_DATA = 0
) (
    input  logic              clk,
    input  logic              regReset,
    input  logic              flush,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [CTRL_W-1:0] up_ctrl,
    input  logic [DATA_W-1:0] up_data,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [CTRL_W-1:0] dn_ctrl,
    output logic [DATA_W-1:0] dn_data,
    output logic [1:0]        occ,
    output logic [31:0]       bubble_cnt,
    output logic [31:0]       stall_cnt
);

    logic              main_valid_s;
    logic [CTRL_W-1:0] main_ctrl_s;
    logic [DATA_W-1:0] main_data_s;
    logic              skid_valid_s;
    logic [CTRL_W-1:0] skid_ctrl_s;
    logic [DATA_W-1:0] skid_data_s;
    logic              up_fire_s;
    logic              dn_fire_s;
    logic              main_load_s;
    logic              main_drop_s;
    logic              main_sel_skid_s;
    logic              skid_load_s;
    logic              skid_drop_s;
    logic              main_in_valid_s;
    logic [CTRL_W-1:0] main_in_ctrl_s;
    logic [DATA_W-1:0] main_in_data_s;

    assign up_fire_s = up_valid & up_ready;
    assign dn_fire_s = main_valid_s & dn_ready;

    generate
        if (SKID != 0) begin : g_skid
            assign up_ready = ~skid_valid_s;

            pipe_slot #(
                .CTRL_W     (CTRL_W),
                .DATA_W     (DATA_W),
                .CLEAR_DATA (CLEAR_DATA)
            ) u_skid (
                .clk      (clk),
                .rst      (regReset),
                .clear    (flush),
                .load     (skid_load_s),
                .drop     (skid_drop_s),
                .in_valid (up_valid),
                .in_ctrl  (up_ctrl),
                .in_data  (up_data),
                .valid    (skid_valid_s),
                .ctrl     (skid_ctrl_s),
                .data     (skid_data_s)
            );
        end else begin : g_noskid
            assign up_ready     = dn_ready | ~main_valid_s;
            assign skid_valid_s = 1'b0;
            assign skid_ctrl_s  = {CTRL_W{1'b0}};
            assign skid_data_s  = {DATA_W{1'b0}};
        end
    endgenerate

    // Slot steering: the skid entry always drains into main before new upstream beats.
    always_comb begin
        main_load_s     = 1'b0;
        main_drop_s     = 1'b0;
        main_sel_skid_s = 1'b0;
        skid_load_s     = 1'b0;
        skid_drop_s     = 1'b0;
        if (SKID == 0) begin
            main_load_s = up_ready;
        end else if (dn_fire_s) begin
            if (skid_valid_s) begin
                main_load_s     = 1'b1;
                main_sel_skid_s = 1'b1;
                skid_drop_s     = 1'b1;
            end else if (up_fire_s) begin
                main_load_s = 1'b1;
            end else begin
                main_drop_s = 1'b1;
            end
        end else if (up_fire_s) begin
            if (main_valid_s) begin
                skid_load_s = 1'b1;
            end else begin
                main_load_s = 1'b1;
            end
        end else begin
            main_load_s = 1'b0;
        end
    end

    assign main_in_valid_s = main_sel_skid_s ? skid_valid_s : up_valid;
    assign main_in_ctrl_s  = main_sel_skid_s ? skid_ctrl_s  : up_ctrl;
    assign main_in_data_s  = main_sel_skid_s ? skid_data_s  : up_data;

    pipe_slot #(
        .CTRL_W     (CTRL_W),
        .DATA_W     (DATA_W),
        .CLEAR_DATA (CLEAR_DATA)
    ) u_main (
        .clk      (clk),
        .rst      (regReset),
        .clear    (flush),
        .load     (main_load_s),
        .drop     (main_drop_s),
        .in_valid (main_in_valid_s),
        .in_ctrl  (main_in_ctrl_s),
        .in_data  (main_in_data_s),
        .valid    (main_valid_s),
        .ctrl     (main_ctrl_s),
        .data     (main_data_s)
    );

    // Invalid beats present NOP control; data is masked only when CLEAR_DATA is set.
    assign dn_valid = main_valid_s;
    assign dn_ctrl  = main_ctrl_s & {CTRL_W{main_valid_s}};
    assign dn_data  = (main_valid_s || (CLEAR_DATA == 0)) ? main_data_s : {DATA_W{1'b0}};
    assign occ      = {1'b0, main_valid_s} + {1'b0, skid_valid_s};

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] bubble_cnt_r;
    logic [31:0] stall_cnt_r;

    // Saturating bubble/stall counters; flush deliberately leaves them alone.
    always_ff @(negedge clk) begin
        if (regReset) begin
            bubble_cnt_r <= 32'd0;
            stall_cnt_r  <= 32'd0;
        end else begin
            if (!main_valid_s && (bubble_cnt_r != 32'hFFFF_FFFF)) begin
                bubble_cnt_r <= bubble_cnt_r + 32'd1;
            end
            if (main_valid_s && !dn_ready && (stall_cnt_r != 32'hFFFF_FFFF)) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end
        end
    end

    assign bubble_cnt = bubble_cnt_r;
    assign stall_cnt  = stall_cnt_r;
`else
    assign bubble_cnt = 32'd0;
    assign stall_cnt  = 32'd0;
`endif

endmodule
